wb_lsu_stage: RTL and testbench

- Parametrised memory-access and writeback stage for the pipelined RISC-V core.
- Replaces the single-cycle data-memory-plus-mux writeback with a valid/ready pipeline stage.
- Drives an external data-memory port with a request/grant/response handshake, supports byte, half and word access with sign/zero extension, and detects misalignment.
- Selects the writeback value from four sources.

---
 rtl/wb_pkg.sv | 24 ++
 rtl/lsu_align.sv | 58 +++++
 rtl/wb_lsu_stage.sv | 162 ++++++++++++++++
 tb/tb_wb_lsu_stage.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared encodings for the memory-access / writeback stage: writeback source
// select, load/store size codes and the access state machine.
package wb_pkg;

    localparam logic [1:0] WB_MEM = 2'd0;
    localparam logic [1:0] WB_ALU = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;
    localparam logic [1:0] WB_IMM = 2'd3;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        WAIT_R = 2'd2
    } state_t;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: store data shift and byte enables, load lane
// extract with sign/zero extension, and the misaligned/illegal-size flag.
module lsu_align import wb_pkg::*; #(
    parameter  int XLEN = 32,
    localparam int NB   = XLEN / 8,
    localparam int OW   = $clog2(NB)
) (
    input  logic [2:0]      st_f3,
    input  logic [OW-1:0]   st_off,
    input  logic [XLEN-1:0] st_data,
    output logic [NB-1:0]   st_be,
    output logic [XLEN-1:0] st_wdata,
    output logic            st_err,
    input  logic [2:0]      ld_f3,
    input  logic [OW-1:0]   ld_off,
    input  logic [XLEN-1:0] ld_rdata,
    output logic [XLEN-1:0] ld_ext
);

    logic [3:0]      st_bytes;
    logic [3:0]      ld_bytes;
    logic [7:0]      lane_mask;
    logic            illegal;
    logic            sign_bit;
    logic [XLEN-1:0] data_mask;
    logic [XLEN-1:0] ld_shift;

    // Access size in bytes is 1 << funct3[1:0]; the address offset must be a multiple of it.
    always_comb begin
        st_bytes  = 4'd1 << st_f3[1:0];
        lane_mask = 8'((16'd1 << st_bytes) - 16'd1);
        illegal   = (st_f3 == 3'b111) || ((XLEN == 32) && (st_f3 == F3_D || st_f3 == F3_WU));
        st_err    = illegal || ((4'(st_off) & (st_bytes - 4'd1)) != 4'd0);
        st_be     = NB'(lane_mask) << st_off;
        data_mask = '0;
        for (int i = 0; i < NB; i++) begin
            data_mask[i*8 +: 8] = {8{lane_mask[i]}};
        end
        st_wdata = (st_data & data_mask) << {st_off, 3'b000};
    end

    always_comb begin
        ld_bytes = 4'd1 << ld_f3[1:0];
        ld_shift = ld_rdata >> {ld_off, 3'b000};
        case (ld_f3[1:0])
            2'd0:    sign_bit = ld_shift[7];
            2'd1:    sign_bit = ld_shift[15];
            2'd2:    sign_bit = ld_shift[31];
            default: sign_bit = ld_shift[XLEN-1];
        endcase
        sign_bit = sign_bit & ~ld_f3[2];
        ld_ext   = '0;
        for (int i = 0; i < XLEN; i++) begin
            ld_ext[i] = (i < 8 * int'(ld_bytes)) ? ld_shift[i] : sign_bit;
        end
    end

endmodule

// File: rtl/wb_lsu_stage.sv
// Memory-access and writeback pipeline stage: issues one data-memory access
// per accepted op (request/grant/response) and produces the writeback result.
module wb_lsu_stage import wb_pkg::*; #(
    parameter  int XLEN = 32,
    parameter  int RD_W = 5,
    localparam int NB   = XLEN / 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            MemEn,
    input  logic            MemRW,
    input  logic [2:0]      funct3,
    input  logic [1:0]      WBSel,
    input  logic            RegWEn_in,
    input  logic [RD_W-1:0] rd_in,
    input  logic [XLEN-1:0] alu_out,
    input  logic [XLEN-1:0] Wr_data,
    input  logic [XLEN-1:0] pc_plus4,
    input  logic [XLEN-1:0] imm,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic [NB-1:0]   mem_be,
    input  logic            mem_gnt,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata,
    output logic [XLEN-1:0] WB_Data,
    output logic            wb_valid,
    output logic            RegWEn_out,
    output logic [RD_W-1:0] rd_out,
    output logic            misalign_err,
    output logic [1:0]      dbg_state
);

    localparam int OW = $clog2(NB);

    // Handshake: an op transfers on a cycle where in_valid && in_ready are both high;
    // a memory beat transfers on mem_req && mem_gnt, and load data on mem_rvalid while a load is pending.
    state_t          state, state_nx;
    logic            accept;
    logic            store_done;
    logic            load_done;
    logic            st_err;
    logic [NB-1:0]   st_be;
    logic [XLEN-1:0] st_wdata;
    logic [XLEN-1:0] ld_ext;
    logic [XLEN-1:0] src_sel;
    logic [XLEN-1:0] op_src;
    logic [2:0]      op_f3;
    logic [1:0]      op_wbsel;
    logic            op_regwen;
    logic [RD_W-1:0] op_rd;
    logic [OW-1:0]   op_off;

    lsu_align #(.XLEN(XLEN)) u_align (
        .st_f3    (funct3),
        .st_off   (alu_out[OW-1:0]),
        .st_data  (Wr_data),
        .st_be    (st_be),
        .st_wdata (st_wdata),
        .st_err   (st_err),
        .ld_f3    (op_f3),
        .ld_off   (op_off),
        .ld_rdata (mem_rdata),
        .ld_ext   (ld_ext)
    );

    always_comb begin
        case (WBSel)
            WB_ALU:  src_sel = alu_out;
            WB_PC4:  src_sel = pc_plus4;
            WB_IMM:  src_sel = imm;
            default: src_sel = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    // A grant that coincides with load data completes the load directly.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept && MemEn && !st_err) state_nx = REQ;
            REQ:     if (mem_gnt) state_nx = (mem_we || mem_rvalid) ? IDLE : WAIT_R;
            WAIT_R:  if (mem_rvalid) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        in_ready   = (state == IDLE);
        mem_req    = (state == REQ);
        dbg_state  = state;
        accept     = in_valid && in_ready;
        store_done = (state == REQ) && mem_gnt && mem_we;
        load_done  = ((state == REQ) && mem_gnt && !mem_we && mem_rvalid) ||
                     ((state == WAIT_R) && mem_rvalid);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_valid     <= 1'b0;
            misalign_err <= 1'b0;
            RegWEn_out   <= 1'b0;
            WB_Data      <= '0;
            rd_out       <= '0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            mem_be       <= '0;
            op_src       <= '0;
            op_f3        <= '0;
            op_wbsel     <= '0;
            op_regwen    <= 1'b0;
            op_rd        <= '0;
            op_off       <= '0;
        end else begin
            wb_valid     <= 1'b0;
            misalign_err <= 1'b0;
            RegWEn_out   <= 1'b0;
            if (accept) begin
                if (!MemEn || st_err) begin
                    wb_valid     <= 1'b1;
                    misalign_err <= MemEn;
                    RegWEn_out   <= !MemEn && RegWEn_in && (rd_in != '0);
                    WB_Data      <= src_sel;
                    rd_out       <= rd_in;
                end else begin
                    mem_addr  <= {alu_out[XLEN-1:OW], {OW{1'b0}}};
                    mem_we    <= MemRW;
                    mem_be    <= st_be;
                    mem_wdata <= MemRW ? st_wdata : '0;
                    op_src    <= src_sel;
                    op_f3     <= funct3;
                    op_wbsel  <= WBSel;
                    op_regwen <= RegWEn_in;
                    op_rd     <= rd_in;
                    op_off    <= alu_out[OW-1:0];
                end
            end
            if (store_done) begin
                wb_valid <= 1'b1;
                mem_we   <= 1'b0;
                WB_Data  <= op_src;
                rd_out   <= op_rd;
            end
            if (load_done) begin
                wb_valid   <= 1'b1;
                WB_Data    <= (op_wbsel == WB_MEM) ? ld_ext : op_src;
                RegWEn_out <= op_regwen && (op_rd != '0);
                rd_out     <= op_rd;
            end
        end
    end

endmodule

// File: tb/tb_wb_lsu_stage.sv
// Self-checking bench for wb_lsu_stage (XLEN=32): directed scenarios plus
// randomized ops checked against a byte-level reference model.
module tb_wb_lsu_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        MemEn = 1'b0;
    logic        MemRW = 1'b0;
    logic [2:0]  funct3 = '0;
    logic [1:0]  WBSel = '0;
    logic        RegWEn_in = 1'b0;
    logic [4:0]  rd_in = '0;
    logic [31:0] alu_out = '0;
    logic [31:0] Wr_data = '0;
    logic [31:0] pc_plus4 = '0;
    logic [31:0] imm = '0;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_gnt = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic [31:0] WB_Data;
    logic        wb_valid;
    logic        RegWEn_out;
    logic [4:0]  rd_out;
    logic        misalign_err;
    logic [1:0]  dbg_state;

    int n_checks = 0;
    int n_fail = 0;
    logic [31:0] exp_q[$];

    bit          obs_done, obs_stable, obs_ready_hi, obs_regwen, obs_mis, obs_we;
    int          obs_req_n;
    logic [31:0] obs_wb, obs_addr, obs_wdata;
    logic [3:0]  obs_be;
    logic [4:0]  obs_rd;

    wb_lsu_stage #(.XLEN(32), .RD_W(5)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .MemEn(MemEn), .MemRW(MemRW), .funct3(funct3), .WBSel(WBSel),
        .RegWEn_in(RegWEn_in), .rd_in(rd_in), .alu_out(alu_out), .Wr_data(Wr_data),
        .pc_plus4(pc_plus4), .imm(imm), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .WB_Data(WB_Data),
        .wb_valid(wb_valid), .RegWEn_out(RegWEn_out), .rd_out(rd_out),
        .misalign_err(misalign_err), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    // Driver: presents one op at the current negedge, plays the memory side with the
    // given grant/response delays, and records what the stage did until wb_valid.
    task automatic do_op(input bit memen, input bit memrw, input logic [2:0] f3,
                         input logic [1:0] wbsel, input bit regwen, input logic [4:0] rd,
                         input logic [31:0] alu, input logic [31:0] wd, input logic [31:0] pc4,
                         input logic [31:0] im, input int gnt_dly, input int rv_dly,
                         input logic [31:0] rdata);
        int  wait_n;
        bit  granted;
        in_valid = 1'b1; MemEn = memen; MemRW = memrw; funct3 = f3; WBSel = wbsel;
        RegWEn_in = regwen; rd_in = rd; alu_out = alu; Wr_data = wd; pc_plus4 = pc4;
        imm = im; mem_rdata = rdata;
        obs_done = 0; obs_req_n = 0; obs_stable = 1; obs_ready_hi = 0;
        granted = 0; wait_n = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            in_valid = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
            if (mem_req) begin
                if (obs_req_n == 0) begin
                    obs_addr = mem_addr; obs_be = mem_be; obs_wdata = mem_wdata; obs_we = mem_we;
                end else if (mem_addr !== obs_addr || mem_be !== obs_be ||
                             mem_wdata !== obs_wdata || mem_we !== obs_we) begin
                    obs_stable = 0;
                end
                obs_req_n++;
            end
            if (wb_valid) begin
                obs_done = 1; obs_wb = WB_Data; obs_regwen = RegWEn_out;
                obs_rd = rd_out; obs_mis = misalign_err;
                break;
            end
            if (in_ready) obs_ready_hi = 1;
            if (mem_req && obs_req_n > gnt_dly) begin
                mem_gnt = 1'b1; granted = 1;
                if (!memrw && rv_dly == 0) mem_rvalid = 1'b1;
            end else if (granted && !memrw) begin
                wait_n++;
                if (wait_n >= rv_dly) mem_rvalid = 1'b1;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req: got %0h want 0", mem_req); end
        n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_mem_we: got %0h want 0", mem_we); end
        n_checks++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL reset_wb_valid: got %0h want 0", wb_valid); end
        n_checks++; if (RegWEn_out !== 1'b0) begin n_fail++; $display("FAIL reset_regwen: got %0h want 0", RegWEn_out); end
        n_checks++; if (misalign_err !== 1'b0) begin n_fail++; $display("FAIL reset_misalign: got %0h want 0", misalign_err); end
        n_checks++; if (WB_Data !== 32'h0) begin n_fail++; $display("FAIL reset_wb_data: got %h want 0", WB_Data); end
        n_checks++; if (rd_out !== 5'h0) begin n_fail++; $display("FAIL reset_rd_out: got %h want 0", rd_out); end
        n_checks++; if (mem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr); end
        n_checks++; if (mem_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_mem_wdata: got %h want 0", mem_wdata); end
        n_checks++; if (mem_be !== 4'h0) begin n_fail++; $display("FAIL reset_mem_be: got %h want 0", mem_be); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %0h want 1", in_ready); end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_nonmem();
        do_op(0, 0, 3'b000, 2'd2, 1, 5'd5, 32'h0000_7777, 32'h0, 32'h104, 32'h5555, 0, 0, 32'h0);
        n_checks++; if (obs_done !== 1'b1) begin n_fail++; $display("FAIL nonmem_done: got %0d want 1", obs_done); end
        n_checks++; if (obs_wb !== 32'h104) begin n_fail++; $display("FAIL nonmem_wb: got %h want 00000104", obs_wb); end
        n_checks++; if (obs_regwen !== 1'b1) begin n_fail++; $display("FAIL nonmem_regwen: got %0d want 1", obs_regwen); end
        n_checks++; if (obs_rd !== 5'd5) begin n_fail++; $display("FAIL nonmem_rd: got %0d want 5", obs_rd); end
        n_checks++; if (obs_req_n != 0) begin n_fail++; $display("FAIL nonmem_no_req: got %0d want 0", obs_req_n); end
        do_op(0, 0, 3'b000, 2'd3, 1, 5'd0, 32'h1, 32'h0, 32'h2, 32'hABCD_E000, 0, 0, 32'h0);
        n_checks++; if (obs_wb !== 32'hABCD_E000) begin n_fail++; $display("FAIL nonmem_imm: got %h want abcde000", obs_wb); end
        n_checks++; if (obs_regwen !== 1'b0) begin n_fail++; $display("FAIL nonmem_rd0_regwen: got %0d want 0", obs_regwen); end
    endtask

    task automatic test_store_byte();
        do_op(1, 1, 3'b000, 2'd1, 1, 5'd7, 32'h1003, 32'hAB, 32'h0, 32'h0, 2, 0, 32'h0);
        n_checks++; if (obs_done !== 1'b1) begin n_fail++; $display("FAIL sb_done: got %0d want 1", obs_done); end
        n_checks++; if (obs_req_n != 3) begin n_fail++; $display("FAIL sb_req_cycles: got %0d want 3", obs_req_n); end
        n_checks++; if (obs_addr !== 32'h1000) begin n_fail++; $display("FAIL sb_addr: got %h want 00001000", obs_addr); end
        n_checks++; if (obs_be !== 4'b1000) begin n_fail++; $display("FAIL sb_be: got %b want 1000", obs_be); end
        n_checks++; if (obs_wdata !== 32'hAB00_0000) begin n_fail++; $display("FAIL sb_wdata: got %h want ab000000", obs_wdata); end
        n_checks++; if (obs_we !== 1'b1) begin n_fail++; $display("FAIL sb_we: got %0d want 1", obs_we); end
        n_checks++; if (obs_stable !== 1'b1) begin n_fail++; $display("FAIL sb_stable: got %0d want 1", obs_stable); end
        n_checks++; if (obs_regwen !== 1'b0) begin n_fail++; $display("FAIL sb_regwen: got %0d want 0", obs_regwen); end
        n_checks++; if (obs_ready_hi !== 1'b0) begin n_fail++; $display("FAIL sb_in_ready: got %0d want 0", obs_ready_hi); end
    endtask

    task automatic test_load_sign();
        do_op(1, 0, 3'b000, 2'd0, 1, 5'd10, 32'h2002, 32'h0, 32'h0, 32'h0, 1, 1, 32'h0080_0000);
        n_checks++; if (obs_wb !== 32'hFFFF_FF80) begin n_fail++; $display("FAIL lb_wb: got %h want ffffff80", obs_wb); end
        n_checks++; if (obs_be !== 4'b0100) begin n_fail++; $display("FAIL lb_be: got %b want 0100", obs_be); end
        n_checks++; if (obs_wdata !== 32'h0) begin n_fail++; $display("FAIL lb_wdata: got %h want 0", obs_wdata); end
        n_checks++; if (obs_regwen !== 1'b1) begin n_fail++; $display("FAIL lb_regwen: got %0d want 1", obs_regwen); end
        do_op(1, 0, 3'b100, 2'd0, 1, 5'd11, 32'h2002, 32'h0, 32'h0, 32'h0, 0, 2, 32'h0080_0000);
        n_checks++; if (obs_wb !== 32'h0000_0080) begin n_fail++; $display("FAIL lbu_wb: got %h want 00000080", obs_wb); end
        n_checks++; if (obs_rd !== 5'd11) begin n_fail++; $display("FAIL lbu_rd: got %0d want 11", obs_rd); end
    endtask

    task automatic test_misalign();
        do_op(1, 0, 3'b010, 2'd0, 1, 5'd3, 32'h3002, 32'h0, 32'h0, 32'h0, 0, 0, 32'h0);
        n_checks++; if (obs_done !== 1'b1) begin n_fail++; $display("FAIL lw_mis_done: got %0d want 1", obs_done); end
        n_checks++; if (obs_req_n != 0) begin n_fail++; $display("FAIL lw_mis_req: got %0d want 0", obs_req_n); end
        n_checks++; if (obs_mis !== 1'b1) begin n_fail++; $display("FAIL lw_mis_err: got %0d want 1", obs_mis); end
        n_checks++; if (obs_regwen !== 1'b0) begin n_fail++; $display("FAIL lw_mis_regwen: got %0d want 0", obs_regwen); end
        do_op(1, 0, 3'b011, 2'd0, 1, 5'd3, 32'h3000, 32'h0, 32'h0, 32'h0, 0, 0, 32'h0);
        n_checks++; if (obs_mis !== 1'b1 || obs_req_n != 0) begin n_fail++; $display("FAIL ld_illegal: got err=%0d req=%0d want err=1 req=0", obs_mis, obs_req_n); end
        do_op(1, 1, 3'b001, 2'd0, 0, 5'd0, 32'h3001, 32'h1234, 32'h0, 32'h0, 0, 0, 32'h0);
        n_checks++; if (obs_mis !== 1'b1 || obs_req_n != 0) begin n_fail++; $display("FAIL sh_mis: got err=%0d req=%0d want err=1 req=0", obs_mis, obs_req_n); end
    endtask

    task automatic test_load_half();
        do_op(1, 0, 3'b001, 2'd0, 1, 5'd12, 32'h4000, 32'h0, 32'h0, 32'h0, 0, 0, 32'h1234_F00D);
        n_checks++; if (obs_wb !== 32'hFFFF_F00D) begin n_fail++; $display("FAIL lh_same_wb: got %h want fffff00d", obs_wb); end
        n_checks++; if (obs_be !== 4'b0011) begin n_fail++; $display("FAIL lh_be: got %b want 0011", obs_be); end
        do_op(1, 0, 3'b001, 2'd0, 1, 5'd12, 32'h4000, 32'h0, 32'h0, 32'h0, 0, 4, 32'h1234_F00D);
        n_checks++; if (obs_wb !== 32'hFFFF_F00D) begin n_fail++; $display("FAIL lh_wait_wb: got %h want fffff00d", obs_wb); end
        n_checks++; if (obs_ready_hi !== 1'b0) begin n_fail++; $display("FAIL lh_wait_ready: got %0d want 0", obs_ready_hi); end
        do_op(1, 0, 3'b001, 2'd1, 1, 5'd13, 32'h4000, 32'h0, 32'h0, 32'h0, 1, 1, 32'h1234_F00D);
        n_checks++; if (obs_wb !== 32'h4000) begin n_fail++; $display("FAIL lh_wbsel_alu: got %h want 00004000", obs_wb); end
    endtask

    task automatic test_reset_in_flight();
        in_valid = 1'b1; MemEn = 1'b1; MemRW = 1'b0; funct3 = 3'b010; WBSel = 2'd0;
        RegWEn_in = 1'b1; rd_in = 5'd9; alu_out = 32'h5000;
        @(negedge clk);
        in_valid = 1'b0;
        n_checks++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL rif_req_up: got %0d want 1", mem_req); end
        rst = 1'b0; #1;
        n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL rif_req_drop: got %0d want 0", mem_req); end
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        @(negedge clk);
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rif_wait_ready: got %0d want 0", in_ready); end
        rst = 1'b0; #1;
        n_checks++; if (mem_req !== 1'b0 || wb_valid !== 1'b0) begin n_fail++; $display("FAIL rif_wait_reset: got req=%0d wbv=%0d want 0 0", mem_req, wb_valid); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rif_ready_idle: got %0d want 1", in_ready); end
        @(negedge clk);
        rst = 1'b1;
        mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        mem_rvalid = 1'b0;
        n_checks++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL rif_stray: got %0d want 0", wb_valid); end
        do_op(1, 0, 3'b010, 2'd0, 1, 5'd9, 32'h6004, 32'h0, 32'h0, 32'h0, 1, 2, 32'hCAFE_BABE);
        n_checks++; if (obs_done !== 1'b1 || obs_wb !== 32'hCAFE_BABE) begin n_fail++; $display("FAIL rif_next_op: got done=%0d wb=%h want 1 cafebabe", obs_done, obs_wb); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] src, want;
        logic [1:0]  sel;
        for (int i = 0; i < 16; i++) begin
            sel = 2'($urandom_range(1, 3));
            alu_out = $urandom; pc_plus4 = $urandom; imm = $urandom;
            src = (sel == 2'd1) ? alu_out : (sel == 2'd2) ? pc_plus4 : imm;
            exp_q.push_back(src);
            in_valid = 1'b1; MemEn = 1'b0; WBSel = sel; RegWEn_in = 1'b1;
            rd_in = 5'($urandom_range(1, 31));
            n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready[%0d]: got %0d want 1", i, in_ready); end
            @(negedge clk);
            want = exp_q.pop_front();
            n_checks++; if (wb_valid !== 1'b1 || WB_Data !== want) begin n_fail++; $display("FAIL b2b_wb[%0d]: got v=%0d d=%h want 1 %h", i, wb_valid, WB_Data, want); end
        end
        in_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_pulse_end: got %0d want 0", wb_valid); end
    endtask

    task automatic test_random();
        bit          memen, memrw, regwen, err, chk_wb;
        logic [2:0]  f3;
        logic [1:0]  wbsel;
        logic [4:0]  rd;
        logic [31:0] alu, wd, pc4, im, rdata, src, lmask, v, e_wd, e_wb;
        logic [3:0]  e_be;
        int          size, off, gd, rv;
        bit          e_regwen;
        for (int i = 0; i < 60; i++) begin
            memen = 1'($urandom_range(0, 1)); memrw = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            wbsel = memen ? 2'($urandom_range(0, 3)) : 2'($urandom_range(1, 3));
            regwen = 1'($urandom_range(0, 1)); rd = 5'($urandom_range(0, 31));
            alu = $urandom; wd = $urandom; pc4 = $urandom; im = $urandom; rdata = $urandom;
            if ($urandom_range(0, 1) == 1) alu[1:0] = 2'b00;
            gd = $urandom_range(0, 3); rv = $urandom_range(0, 3);
            size = 1 << f3[1:0];
            off = int'(alu[1:0]);
            err = memen && ((f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) || ((alu & 32'(size - 1)) != 0));
            src = (wbsel == 2'd1) ? alu : (wbsel == 2'd2) ? pc4 : (wbsel == 2'd3) ? im : 32'h0;
            lmask = (size >= 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 32'd1);
            e_be = 4'(((1 << size) - 1) << off);
            e_wd = memrw ? ((wd & lmask) << (8 * off)) : 32'h0;
            v = (rdata >> (8 * off)) & lmask;
            if (!f3[2] && size < 4 && v[8*size-1]) v = v | ~lmask;
            e_wb = (memen && wbsel == 2'd0) ? v : src;
            chk_wb = !err && !(memen && memrw);
            e_regwen = chk_wb && regwen && (rd != 5'd0);
            do_op(memen, memrw, f3, wbsel, regwen, rd, alu, wd, pc4, im, gd, rv, rdata);
            n_checks++; if (obs_done !== 1'b1) begin n_fail++; $display("FAIL rnd_done[%0d]: got %0d want 1", i, obs_done); end
            n_checks++; if (obs_mis !== err) begin n_fail++; $display("FAIL rnd_mis[%0d]: got %0d want %0d", i, obs_mis, err); end
            n_checks++; if (obs_regwen !== e_regwen) begin n_fail++; $display("FAIL rnd_regwen[%0d]: got %0d want %0d", i, obs_regwen, e_regwen); end
            n_checks++; if (obs_rd !== rd) begin n_fail++; $display("FAIL rnd_rd[%0d]: got %0d want %0d", i, obs_rd, rd); end
            if (chk_wb) begin
                n_checks++; if (obs_wb !== e_wb) begin n_fail++; $display("FAIL rnd_wb[%0d]: got %h want %h", i, obs_wb, e_wb); end
            end
            if (memen && !err) begin
                n_checks++; if (obs_req_n != gd + 1) begin n_fail++; $display("FAIL rnd_req_n[%0d]: got %0d want %0d", i, obs_req_n, gd + 1); end
                n_checks++; if (obs_addr !== {alu[31:2], 2'b00}) begin n_fail++; $display("FAIL rnd_addr[%0d]: got %h want %h", i, obs_addr, {alu[31:2], 2'b00}); end
                n_checks++; if (obs_be !== e_be) begin n_fail++; $display("FAIL rnd_be[%0d]: got %b want %b", i, obs_be, e_be); end
                n_checks++; if (obs_wdata !== e_wd) begin n_fail++; $display("FAIL rnd_wdata[%0d]: got %h want %h", i, obs_wdata, e_wd); end
                n_checks++; if (obs_we !== memrw || obs_stable !== 1'b1) begin n_fail++; $display("FAIL rnd_we_stable[%0d]: got we=%0d st=%0d want %0d 1", i, obs_we, obs_stable, memrw); end
                n_checks++; if (obs_ready_hi !== 1'b0) begin n_fail++; $display("FAIL rnd_ready[%0d]: got %0d want 0", i, obs_ready_hi); end
            end else begin
                n_checks++; if (obs_req_n != 0) begin n_fail++; $display("FAIL rnd_no_req[%0d]: got %0d want 0", i, obs_req_n); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_nonmem();
        test_store_byte();
        test_load_sign();
        test_misalign();
        test_load_half();
        test_reset_in_flight();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
